// File: rtl/nn_seq_ctrl_if.sv
// rtl/nn_seq_ctrl_if.sv - control/handshake bundle between nn_seq_ctrl and its datapath/memory
interface nn_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            r_sh_en;
  logic [1:0]            mac_en;
  logic [1:0]            mac_clr;
  logic                  arg_zero;
  logic [ADDR_WIDTH-1:0] lut_pos;
  logic                  lut_sel;
  logic [ADDR_WIDTH-1:0] lut_idx;

  modport master (
    input  start, arg_zero, lut_idx,
    output busy, done, mem_addr, r_sh_en, mac_en, mac_clr, lut_pos, lut_sel
  );

  modport slave (
    output start, arg_zero, lut_idx,
    input  busy, done, mem_addr, r_sh_en, mac_en, mac_clr, lut_pos, lut_sel
  );
endinterface

// File: rtl/nn_seq_ctrl.sv
// rtl/nn_seq_ctrl.sv - two-layer MLP inference sequencer (addresses, shift/MAC strobes, sigmoid LUT lookups)
// Optional macro NN_SEQ_SKIP_ZERO_EN: pixels whose arg is +/-0 skip the layer-1 weight fetch and MAC.
module nn_seq_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int N_IN       = 784,
  parameter int N_HID      = 25,
  parameter int N_OUT      = 10,
  parameter int IMG_BASE   = 0,
  parameter int W1_BASE    = 784,
  parameter int W2_BASE    = 20384,
  parameter int LUT_BASE   = 20644
) (
  input  logic          clk,
  input  logic          rst,
  nn_seq_ctrl_if.master bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLR    = 4'd1;
  localparam logic [3:0] S_A_ADDR = 4'd2;
  localparam logic [3:0] S_A_LD   = 4'd3;
  localparam logic [3:0] S_A_CHK  = 4'd4;
  localparam logic [3:0] S_W1     = 4'd5;
  localparam logic [3:0] S_M1     = 4'd6;
  localparam logic [3:0] S_W2     = 4'd7;
  localparam logic [3:0] S_L2_LUT = 4'd8;
  localparam logic [3:0] S_M2     = 4'd9;
  localparam logic [3:0] S_O_LUT  = 4'd10;
  localparam logic [3:0] S_O_SH   = 4'd11;
  localparam logic [3:0] S_DONE   = 4'd12;

  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(N_IN - 1);
  localparam logic [ADDR_WIDTH-1:0] HID_A    = ADDR_WIDTH'(N_HID);
  localparam logic [ADDR_WIDTH-1:0] OUT_A    = ADDR_WIDTH'(N_OUT);
  localparam logic [ADDR_WIDTH-1:0] LAST_OUT = ADDR_WIDTH'(N_OUT - 1);
  localparam logic [ADDR_WIDTH-1:0] IMG_A    = ADDR_WIDTH'(IMG_BASE);
  localparam logic [ADDR_WIDTH-1:0] W1_A     = ADDR_WIDTH'(W1_BASE);
  localparam logic [ADDR_WIDTH-1:0] W2_A     = ADDR_WIDTH'(W2_BASE);
  localparam logic [ADDR_WIDTH-1:0] LUT_A    = ADDR_WIDTH'(LUT_BASE);

  logic [3:0]            state;
  logic [ADDR_WIDTH-1:0] p;   // pixel
  logic [ADDR_WIDTH-1:0] k;   // cycle within W1/W2 burst
  logic [ADDR_WIDTH-1:0] h;   // hidden position, 0 = bias slot
  logic [ADDR_WIDTH-1:0] o;   // output position

`ifndef NN_SEQ_SKIP_ZERO_EN
  logic unused_arg_zero;
  assign unused_arg_zero = bus.arg_zero;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      p     <= '0;
      k     <= '0;
      h     <= '0;
      o     <= '0;
    end else begin
      case (state)
        S_IDLE:   if (bus.start) state <= S_CLR;
        S_CLR: begin
          p     <= '0;
          state <= S_A_ADDR;
        end
        S_A_ADDR: state <= S_A_LD;
        S_A_LD:   state <= S_A_CHK;
        S_A_CHK: begin
`ifdef NN_SEQ_SKIP_ZERO_EN
          if (bus.arg_zero) begin
            if (p == LAST_PIX) begin
              h     <= '0;
              k     <= '0;
              state <= S_W2;
            end else begin
              p     <= p + ONE;
              state <= S_A_ADDR;
            end
          end else begin
            k     <= '0;
            state <= S_W1;
          end
`else
          k     <= '0;
          state <= S_W1;
`endif
        end
        S_W1: begin
          if (k == HID_A) state <= S_M1;
          else            k     <= k + ONE;
        end
        S_M1: begin
          if (p == LAST_PIX) begin
            h     <= '0;
            k     <= '0;
            state <= S_W2;
          end else begin
            p     <= p + ONE;
            state <= S_A_ADDR;
          end
        end
        S_W2: begin
          if (k == OUT_A) state <= S_L2_LUT;
          else            k     <= k + ONE;
        end
        S_L2_LUT: state <= S_M2;
        // N_HID+1 passes through W2: the extra h=0 slot carries the bias
        S_M2: begin
          if (h < HID_A) begin
            h     <= h + ONE;
            k     <= '0;
            state <= S_W2;
          end else begin
            o     <= '0;
            state <= S_O_LUT;
          end
        end
        S_O_LUT: state <= S_O_SH;
        S_O_SH: begin
          if (o == LAST_OUT) state <= S_DONE;
          else begin
            o     <= o + ONE;
            state <= S_O_LUT;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.done     = 1'b0;
    bus.mem_addr = '0;
    bus.r_sh_en  = 4'b0000;
    bus.mac_en   = 2'b00;
    bus.mac_clr  = 2'b00;
    bus.lut_pos  = '0;
    bus.lut_sel  = 1'b0;
    case (state)
      S_CLR:    bus.mac_clr = 2'b11;
      S_A_ADDR: bus.mem_addr = IMG_A + p;
      S_A_LD:   bus.r_sh_en = 4'b0001;
      S_W1: begin
        if (k != HID_A) bus.mem_addr = W1_A + p * HID_A + k;
        if (k != '0)    bus.r_sh_en[1] = 1'b1;
      end
      S_M1:     bus.mac_en = 2'b01;
      S_W2: begin
        bus.lut_pos = h;
        if (k != OUT_A) bus.mem_addr = W2_A + h * OUT_A + k;
        if (k != '0)    bus.r_sh_en[2] = 1'b1;
      end
      S_L2_LUT: begin
        bus.lut_pos  = h;
        bus.mem_addr = LUT_A + bus.lut_idx;
      end
      S_M2: begin
        bus.lut_pos  = h;
        bus.mem_addr = LUT_A + bus.lut_idx;
        bus.mac_en   = 2'b10;
      end
      S_O_LUT: begin
        bus.lut_sel  = 1'b1;
        bus.lut_pos  = o;
        bus.mem_addr = LUT_A + bus.lut_idx;
      end
      S_O_SH: begin
        bus.lut_sel  = 1'b1;
        bus.lut_pos  = o;
        bus.mem_addr = LUT_A + bus.lut_idx;
        bus.r_sh_en  = 4'b1000;
      end
      S_DONE:   bus.done = 1'b1;
      default:  bus.done = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// tb/tb_nn_seq_ctrl.sv - self-checking bench for nn_seq_ctrl (table rows, held start, mid-run reset, random image)
module tb_nn_seq_ctrl;

  localparam int NI  = 784;
  localparam int NH  = 25;
  localparam int NO  = 10;
  localparam int W1B = 784;
  localparam int W2B = 20384;
  localparam int LB  = 20644;
`ifdef NN_SEQ_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [16:0] addr;
    logic [3:0]  sh;
    logic [1:0]  mac;
    logic [1:0]  clr;
    logic [16:0] pos;
    logic        sel;
    logic        busy;
    logic        done;
  } out_t;

  typedef struct {
    int pattern;   // 0: all nonzero, 1: only pixel 5 nonzero
    bit hold;      // keep start high for the whole run
    int lat;
    int mac1;
    int sh1;
    int mac2;
    int sh3;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nn_seq_ctrl_if #(.ADDR_WIDTH(17)) dif();
  nn_seq_ctrl dut (.clk(clk), .rst(rst), .bus(dif));

  bit   zero_pix[NI];
  logic mem_q   = 1'b0;
  logic arg_reg = 1'b0;
  out_t trace[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [16:0] lut_f(input logic [16:0] pos, input logic sel);
    int v;
    v = sel ? (300 + int'(pos) * 3) : (50 + int'(pos) * 7);
    return 17'(v);
  endfunction

  // memory returns the zero flag of a pixel one cycle after its address; arg loads on r_sh_en[0]
  always @(posedge clk) begin
    if (int'(dif.mem_addr) < NI) mem_q <= zero_pix[int'(dif.mem_addr)];
    else                         mem_q <= 1'b0;
    if (dif.r_sh_en[0]) arg_reg <= mem_q;
  end
  assign dif.arg_zero = arg_reg;
  assign dif.lut_idx  = lut_f(dif.lut_pos, dif.lut_sel);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic out_t sample();
    out_t r;
    r.addr = dif.mem_addr; r.sh = dif.r_sh_en; r.mac = dif.mac_en; r.clr = dif.mac_clr;
    r.pos = dif.lut_pos; r.sel = dif.lut_sel; r.busy = dif.busy; r.done = dif.done;
    return r;
  endfunction

  function automatic void push(input int a, input int sh, input int mac, input int clr,
                               input int pos, input bit sel, input bit busy, input bit done);
    out_t r;
    r.addr = 17'(a); r.sh = 4'(sh); r.mac = 2'(mac); r.clr = 2'(clr);
    r.pos = 17'(pos); r.sel = sel; r.busy = busy; r.done = done;
    trace.push_back(r);
  endfunction

  // expected per-cycle outputs from CLR through the IDLE cycle after DONE
  function automatic void build_trace();
    trace.delete();
    push(0, 0, 0, 3, 0, 0, 1, 0);
    for (int p = 0; p < NI; p++) begin
      push(p, 0, 0, 0, 0, 0, 1, 0);
      push(0, 1, 0, 0, 0, 0, 1, 0);
      push(0, 0, 0, 0, 0, 0, 1, 0);
      if (SKIP && zero_pix[p]) continue;
      for (int k = 0; k <= NH; k++)
        push((k < NH) ? W1B + p * NH + k : 0, (k > 0) ? 2 : 0, 0, 0, 0, 0, 1, 0);
      push(0, 0, 1, 0, 0, 0, 1, 0);
    end
    for (int h = 0; h <= NH; h++) begin
      for (int k = 0; k <= NO; k++)
        push((k < NO) ? W2B + h * NO + k : 0, (k > 0) ? 4 : 0, 0, 0, h, 0, 1, 0);
      push(LB + int'(lut_f(17'(h), 1'b0)), 0, 0, 0, h, 0, 1, 0);
      push(LB + int'(lut_f(17'(h), 1'b0)), 0, 2, 0, h, 0, 1, 0);
    end
    for (int o = 0; o < NO; o++) begin
      push(LB + int'(lut_f(17'(o), 1'b1)), 0, 0, 0, o, 1, 1, 0);
      push(LB + int'(lut_f(17'(o), 1'b1)), 8, 0, 0, o, 1, 1, 0);
    end
    push(0, 0, 0, 0, 0, 0, 1, 1);
    push(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic int model_latency();
    int n = 1;
    for (int p = 0; p < NI; p++) n += (SKIP && zero_pix[p]) ? 3 : 30;
    return n + (NH + 1) * 13 + NO * 2 + 1;
  endfunction

  function automatic int model_mac1();
    int n = 0;
    for (int p = 0; p < NI; p++) if (!(SKIP && zero_pix[p])) n++;
    return n;
  endfunction

  // entered between edges while the DUT idles; leaves start high if hold is set
  task automatic do_run(input string tag, input bit hold, output int lat, output int mac1,
                        output int sh1, output int mac2, output int sh3, output int dones);
    out_t obs;
    int   terr = 0;
    int   first = -1;
    out_t fo, fe;
    lat = 0; mac1 = 0; sh1 = 0; mac2 = 0; sh3 = 0; dones = 0;
    build_trace();
    dif.start = 1'b1;
    for (int n = 0; n < trace.size(); n++) begin
      @(posedge clk); #1;
      if (!hold) dif.start = 1'b0;
      @(negedge clk);
      obs = sample();
      if (obs !== trace[n]) begin
        terr++;
        if (first < 0) begin first = n; fo = obs; fe = trace[n]; end
      end
      if (obs.mac[0]) mac1++;
      if (obs.sh[1])  sh1++;
      if (obs.mac[1]) mac2++;
      if (obs.sh[3])  sh3++;
      if (obs.done) begin dones++; lat = n + 1; end
    end
    check({tag, "_trace_mismatches"}, 64'(terr), 64'd0);
    if (first >= 0) $display("  %s first divergence at cycle %0d: dut=%h model=%h", tag, first + 1, fo, fe);
  endtask

  vec_t tbl[2];
  int   lat, mac1, sh1, mac2, sh3, dones;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{pattern: 1, hold: 1'b0,
`ifdef NN_SEQ_SKIP_ZERO_EN
               lat: 2739, mac1: 1, sh1: 25,
`else
               lat: 23880, mac1: 784, sh1: 19600,
`endif
               mac2: 26, sh3: 10};
    tbl[1] = '{pattern: 0, hold: 1'b1, lat: 23880, mac1: 784, sh1: 19600, mac2: 26, sh3: 10};

    dif.start = 1'b0;
    #3;
    check("reset_outputs", 64'(sample()), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_held_outputs", 64'(sample()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outputs", 64'(sample()), 64'd0);

    for (int i = 0; i < 2; i++) begin
      foreach (zero_pix[p]) zero_pix[p] = (tbl[i].pattern == 1) ? (p != 5) : 1'b0;
      do_run($sformatf("row%0d", i), tbl[i].hold, lat, mac1, sh1, mac2, sh3, dones);
      check($sformatf("row%0d_latency", i), 64'(lat),   64'(tbl[i].lat));
      check($sformatf("row%0d_mac1", i),    64'(mac1),  64'(tbl[i].mac1));
      check($sformatf("row%0d_sh1", i),     64'(sh1),   64'(tbl[i].sh1));
      check($sformatf("row%0d_mac2", i),    64'(mac2),  64'(tbl[i].mac2));
      check($sformatf("row%0d_sh3", i),     64'(sh3),   64'(tbl[i].sh3));
      check($sformatf("row%0d_done", i),    64'(dones), 64'd1);
    end

    // start still held: the IDLE cycle accepts it again, then a reset abandons that run
    @(posedge clk); #1;
    @(negedge clk);
    check("reaccept_clr", {62'd0, dif.mac_clr}, 64'd3);
    check("reaccept_busy", 64'(dif.busy), 64'd1);
    dif.start = 1'b0;
    dones = 0;
    for (int c = 2; c < 1000; c++) begin
      @(negedge clk);
      if (dif.done) dones++;
    end
    @(posedge clk); #1;
    check("midrun_busy_before_reset", 64'(dif.busy), 64'd1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", 64'(sample()), 64'd0);
    check("midrun_no_done", 64'(dones), 64'd0);
    repeat (2) begin
      @(negedge clk);
      if (dif.done) dones++;
    end
    check("reset_low_no_done", 64'(dones), 64'd0);
    rst = 1'b1;

    foreach (zero_pix[p]) zero_pix[p] = ($urandom_range(0, 3) == 0);
    do_run("random", 1'b0, lat, mac1, sh1, mac2, sh3, dones);
    check("random_latency", 64'(lat),   64'(model_latency()));
    check("random_mac1",    64'(mac1),  64'(model_mac1()));
    check("random_sh1",     64'(sh1),   64'(model_mac1() * NH));
    check("random_mac2",    64'(mac2),  64'(NH + 1));
    check("random_sh3",     64'(sh3),   64'(NO));
    check("random_done",    64'(dones), 64'd1);

    repeat (3) @(negedge clk);
    check("idle_after_run", 64'(sample()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
